// File: rtl/obi_pkg.sv
// obi_pkg: shared response type and widths for the OBI subordinate
package obi_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BE_WIDTH);
  localparam int ERR_CNT_WIDTH = 8;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } obi_rsp_t;
endpackage

// File: rtl/obi_rsp_fifo.sv
// obi_rsp_fifo: in-order response queue, any depth, pointers wrap modulo DEPTH
module obi_rsp_fifo
  import obi_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = obi_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  T mem_q [DEPTH];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? nxt(wr_q) : wr_q;
    rd_d    = do_pop ? nxt(rd_q) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= wdata_i;
    end
  end
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
endmodule

// File: rtl/obi_subordinate.sv
// obi_subordinate: OBI responder with local word memory, in-order response FIFO and error counter
module obi_subordinate
  import obi_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MEM_WORDS       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]    obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [DATA_WIDTH/8-1:0]  obi_be_i,
  input  logic [DATA_WIDTH-1:0]    obi_wdata_i,
  output logic                     obi_rvalid_o,
  input  logic                     obi_rready_i,
  output logic [DATA_WIDTH-1:0]    obi_rdata_o,
  output logic                     obi_err_o,
  input  logic                     stall_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int AOFS = $clog2(BE_W);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] off;
  logic [IW-1:0] idx;
  logic dec_err, hs, full, empty;
  logic [CW-1:0] cnt;
  rsp_t push_rsp, head;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  always_comb begin
    off     = obi_addr_i - BASE_ADDR;
    idx     = off[AOFS +: IW];
    dec_err = (obi_addr_i < BASE_ADDR) || ((off >> AOFS) >= ADDR_WIDTH'(MEM_WORDS)) ||
              (obi_addr_i[AOFS-1:0] != '0) || (obi_be_i == '0);
    hs      = obi_req_i && obi_gnt_o;
    push_rsp.rdata = (obi_we_i || dec_err) ? '0 : mem_q[idx];
    push_rsp.err   = dec_err;
    err_cnt_d = (hs && dec_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  // memory is deliberately not reset; grant is low in reset so no write lands then
  always_ff @(posedge clk_i) begin
    if (hs && obi_we_i && !dec_err)
      for (int k = 0; k < BE_W; k++)
        if (obi_be_i[k]) mem_q[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
  end
  obi_rsp_fifo #(.DEPTH(MAX_OUTSTANDING), .T(rsp_t)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (hs),
    .wdata_i (push_rsp),
    .pop_i   (obi_rvalid_o && obi_rready_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
  assign obi_gnt_o    = !reset_i && !stall_i && !full;
  assign obi_rvalid_o = cnt != '0;
  assign obi_rdata_o  = empty ? '0 : head.rdata;
  assign obi_err_o    = !empty && head.err;
  assign err_cnt_o    = err_cnt_q;
endmodule

// File: tb/tb_obi_subordinate.sv
// tb_obi_subordinate: randomized bench against a queue/array model of the OBI subordinate
module tb_obi_subordinate;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, req = 1, we = 0, rready = 0, stall = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 4'hF;
  logic gnt, rvalid, err;
  logic [31:0] rdata;
  logic [7:0] err_cnt;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] d; logic e;} rsp_s;
  rsp_s q[$];
  logic [31:0] mm [256];
  int ecnt = 0;
  bit live = 0, m_hs, m_bad;

  obi_subordinate dut (
    .clk_i(clk), .reset_i(rst), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
    .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err), .stall_i(stall),
    .err_cnt_o(err_cnt)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit exp_gnt();
    return !rst && !stall && q.size() < 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ecnt = 0;
      live = 1;
    end else begin
      m_hs = req && exp_gnt();
      if (q.size() != 0 && rready) void'(q.pop_front());
      if (m_hs) begin
        m_bad = addr >= 32'h400 || addr[1:0] != 2'b00 || be == 4'h0;
        if (m_bad) begin
          q.push_back('{32'h0, 1'b1});
          if (ecnt < 255) ecnt++;
        end else if (we) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) mm[addr[9:2]][8*k +: 8] = wdata[8*k +: 8];
          q.push_back('{32'h0, 1'b0});
        end else q.push_back('{mm[addr[9:2]], 1'b0});
      end
    end
  end

  always @(negedge clk) if (live) begin
    chk("gnt", gnt, exp_gnt());
    chk("rvalid", rvalid, q.size() != 0);
    chk("rdata", rdata, q.size() != 0 ? q[0].d : 32'h0);
    chk("err", err, q.size() != 0 ? q[0].e : 1'b0);
    chk("err_cnt", err_cnt, ecnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = w; addr = a; wdata = d; be = b;
    tick();
    req = 0;
  endtask

  initial begin
    tick();
    chk("rst_gnt", gnt, 0); chk("rst_rvalid", rvalid, 0); chk("rst_errcnt", err_cnt, 0);
    tick();
    chk("rst_gnt2", gnt, 0);
    rst = 0; req = 0;
    #1 chk("post_rst_gnt", gnt, 1);
    rready = 1;
    for (int i = 0; i < 256; i++) acc(1, i * 4, $urandom, 4'hF);
    tick();
    acc(1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_rvalid", rvalid, 1); chk("wr_err", err, 0);
    acc(0, 32'h10, 0, 4'hF);
    chk("rd_rvalid", rvalid, 1); chk("rd_data", rdata, 32'hDEADBEEF);
    acc(1, 32'h10, 32'h12345678, 4'b0011);
    acc(0, 32'h10, 0, 4'hF);
    chk("be_data", rdata, 32'hDEAD5678);
    tick();
    rready = 0;
    acc(0, 32'h10, 0, 4'hF);
    acc(0, 32'h14, 0, 4'hF);
    req = 1; addr = 32'h18;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_gnt", gnt, 0);
      chk("bp_rvalid", rvalid, 1); chk("bp_data", rdata, 32'hDEAD5678);
      tick();
    end
    rready = 1;
    tick();
    chk("bp_gnt_after_pop", gnt, 1); chk("bp_second", rdata, mm[5]);
    tick();
    req = 0;
    chk("bp_third", rdata, mm[6]);
    tick();
    chk("bp_drained", rvalid, 0);
    acc(1, 32'h400, 32'hFFFFFFFF, 4'hF);
    chk("e1_err", err, 1); chk("e1_data", rdata, 0);
    acc(0, 32'h2, 0, 4'hF);
    chk("e2_err", err, 1); chk("e2_data", rdata, 0);
    acc(1, 32'h20, 32'h11111111, 4'h0);
    chk("e3_err", err, 1); chk("e3_cnt", err_cnt, 3);
    acc(0, 32'h10, 0, 4'hF);
    chk("e_mem", rdata, 32'hDEAD5678); chk("e_mem_err", err, 0);
    tick();
    rready = 0;
    acc(0, 32'h10, 0, 4'hF);
    acc(0, 32'h14, 0, 4'hF);
    rst = 1;
    tick();
    rst = 0;
    #1 chk("mr_rvalid", rvalid, 0);
    chk("mr_cnt", err_cnt, 0); chk("mr_gnt", gnt, 1);
    rready = 1;
    acc(0, 32'h10, 0, 4'hF);
    chk("mr_mem", rdata, 32'hDEAD5678);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < (p == 0 ? 3000 : 1000); i++) begin
        int r;
        r = $urandom % 8;
        req = ($urandom % 10) < 7;
        we = $urandom % 2;
        addr = r < 5 ? {22'h0, 8'($urandom), 2'b00} :
               r == 5 ? {22'h0, 8'($urandom), 2'($urandom % 3 + 1)} :
               r == 6 ? 32'h400 + ($urandom % 256) * 4 : $urandom;
        be = ($urandom % 16 == 0) ? 4'h0 : 4'($urandom);
        wdata = $urandom;
        rready = ($urandom % 10) < 7;
        stall = ($urandom % 10) == 0;
        rst = p == 1 && ($urandom % 50) == 0;
        tick();
        if (p == 0 && i == 2999) chk("sat_cnt", err_cnt, 8'hFF);
      end
    rst = 0; req = 0; stall = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
